// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and widths for the IF/LS single-port memory arbiter.
package rv_mem_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int RAM_AMOUNT = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RD_WAIT = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// IF/LS request-response and memory command signals for the memory port arbiter.
// Requests: req plus its payload are held until gnt is seen high in the same cycle;
// gnt is the single-cycle accept, and rvalid is a one-cycle completion pulse.
interface mem_port_arbiter_if
  import rv_mem_pkg::*;
  ;
  logic                  if_req;
  logic [DATA_WIDTH-1:0] if_addr;
  logic                  if_gnt;
  logic                  if_rvalid;
  logic [DATA_WIDTH-1:0] if_rdata;
  logic                  if_err;

  logic                  ls_req;
  logic                  ls_we;
  logic [RAM_AMOUNT-1:0] ls_ctrl;
  logic [DATA_WIDTH-1:0] ls_addr;
  logic [DATA_WIDTH-1:0] ls_wdata;
  logic                  ls_gnt;
  logic                  ls_rvalid;
  logic [DATA_WIDTH-1:0] ls_rdata;
  logic                  ls_err;

  logic                  mem_we;
  logic                  mem_rd;
  logic [RAM_AMOUNT-1:0] mem_ctrl;
  logic [DATA_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_di;
  logic [DATA_WIDTH-1:0] mem_dout;
  logic                  mem_dout_ready;

  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_ctrl, ls_addr, ls_wdata,
           mem_dout, mem_dout_ready,
    output if_gnt, if_rvalid, if_rdata, if_err,
           ls_gnt, ls_rvalid, ls_rdata, ls_err,
           mem_we, mem_rd, mem_ctrl, mem_addr, mem_di
  );

  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_ctrl, ls_addr, ls_wdata,
           mem_dout, mem_dout_ready,
    input  if_gnt, if_rvalid, if_rdata, if_err,
           ls_gnt, ls_rvalid, ls_rdata, ls_err,
           mem_we, mem_rd, mem_ctrl, mem_addr, mem_di
  );
endinterface

// File: rtl/mem_port_arbiter_prio.sv
// Winner select between IF and LS: LS first, but IF is forced through after
// MAX_STREAK consecutive LS wins while a fetch was waiting.
module mem_arb_prio #(
  parameter int MAX_STREAK = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic arb_en,
  input  logic if_req,
  input  logic ls_req,
  output logic gnt_if,
  output logic gnt_ls
);
  localparam int SW = $clog2(MAX_STREAK + 1);

  logic [SW-1:0] streak;
  logic          if_turn;

  always_comb begin
    if_turn = (streak == SW'(MAX_STREAK));
    gnt_if  = 1'b0;
    gnt_ls  = 1'b0;
    if (arb_en) begin
      if (if_req && (!ls_req || if_turn)) gnt_if = 1'b1;
      else if (ls_req)                    gnt_ls = 1'b1;
    end
  end

  // Streak only measures LS wins that actually made a fetch wait.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                        streak <= '0;
    else if (!if_req || gnt_if)                     streak <= '0;
    else if (gnt_ls && streak != SW'(MAX_STREAK))   streak <= streak + 1'b1;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store:
// grant, one-cycle registered command, wait for read data with a timeout guard.
module mem_port_arbiter
  import rv_mem_pkg::*;
#(
  parameter int MAX_STREAK = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_port_arbiter_if.slave    bus,
  output state_e               dbg_state
);
  localparam int TW = $clog2(TIMEOUT + 1);

  state_e                state;
  owner_e                owner;
  logic [TW-1:0]         tmr;
  logic                  arb_en, gnt_if, gnt_ls, rd_done;

  logic                  mem_we_q, mem_rd_q;
  logic [RAM_AMOUNT-1:0] mem_ctrl_q;
  logic [DATA_WIDTH-1:0] mem_addr_q, mem_di_q;
  logic                  if_rvalid_q, if_err_q, ls_rvalid_q, ls_err_q;
  logic [DATA_WIDTH-1:0] if_rdata_q, ls_rdata_q;

  assign arb_en  = (state == IDLE) && !rst;
  assign rd_done = bus.mem_dout_ready || (tmr == TW'(TIMEOUT - 1));

  mem_arb_prio #(.MAX_STREAK(MAX_STREAK)) u_prio (
    .clk    (clk),
    .rst    (rst),
    .arb_en (arb_en),
    .if_req (bus.if_req),
    .ls_req (bus.ls_req),
    .gnt_if (gnt_if),
    .gnt_ls (gnt_ls)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      owner       <= OWN_IF;
      tmr         <= '0;
      mem_we_q    <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_ctrl_q  <= '0;
      mem_addr_q  <= '0;
      mem_di_q    <= '0;
      if_rvalid_q <= 1'b0;
      if_err_q    <= 1'b0;
      if_rdata_q  <= '0;
      ls_rvalid_q <= 1'b0;
      ls_err_q    <= 1'b0;
      ls_rdata_q  <= '0;
    end else begin
      // Strobes and response pulses are single-cycle by default.
      mem_we_q    <= 1'b0;
      mem_rd_q    <= 1'b0;
      if_rvalid_q <= 1'b0;
      if_err_q    <= 1'b0;
      if_rdata_q  <= '0;
      ls_rvalid_q <= 1'b0;
      ls_err_q    <= 1'b0;
      ls_rdata_q  <= '0;
      case (state)
        IDLE: begin
          if (gnt_if) begin
            owner      <= OWN_IF;
            mem_rd_q   <= 1'b1;
            mem_ctrl_q <= '1;
            mem_addr_q <= bus.if_addr;
            mem_di_q   <= '0;
            state      <= ISSUE;
          end else if (gnt_ls) begin
            if (bus.ls_ctrl == '0) begin
              ls_rvalid_q <= 1'b1;
              ls_err_q    <= 1'b1;
            end else begin
              owner      <= OWN_LS;
              mem_we_q   <= bus.ls_we;
              mem_rd_q   <= !bus.ls_we;
              mem_ctrl_q <= bus.ls_ctrl;
              mem_addr_q <= bus.ls_addr;
              mem_di_q   <= bus.ls_we ? bus.ls_wdata : '0;
              state      <= ISSUE;
            end
          end
        end
        ISSUE: begin
          tmr <= '0;
          if (mem_we_q) begin
            ls_rvalid_q <= 1'b1;
            state       <= IDLE;
          end else begin
            state <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (rd_done) begin
            state <= IDLE;
            tmr   <= '0;
            if (owner == OWN_IF) begin
              if_rvalid_q <= 1'b1;
              if_err_q    <= !bus.mem_dout_ready;
              if_rdata_q  <= bus.mem_dout_ready ? bus.mem_dout : '0;
            end else begin
              ls_rvalid_q <= 1'b1;
              ls_err_q    <= !bus.mem_dout_ready;
              ls_rdata_q  <= bus.mem_dout_ready ? bus.mem_dout : '0;
            end
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.if_gnt    = gnt_if;
  assign bus.ls_gnt    = gnt_ls;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_rd    = mem_rd_q;
  assign bus.mem_ctrl  = mem_ctrl_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_di    = mem_di_q;
  assign bus.if_rvalid = if_rvalid_q;
  assign bus.if_err    = if_err_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.ls_rvalid = ls_rvalid_q;
  assign bus.ls_err    = ls_err_q;
  assign bus.ls_rdata  = ls_rdata_q;
  assign dbg_state     = state;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: queued requesters, a behavioural memory, and a
// reference model predicting grants, memory commands and responses with cycle stamps.
module tb_mem_port_arbiter;
  import rv_mem_pkg::*;

  localparam int MAX_STREAK = 4;
  localparam int TIMEOUT    = 16;

  typedef struct { logic we; logic [3:0] ctrl; logic [31:0] addr; logic [31:0] wdata; } ls_item_t;
  typedef struct { logic [31:0] rdata; logic err; int cyc; } rsp_t;
  typedef struct { logic we; logic [3:0] ctrl; logic [31:0] addr; logic [31:0] di; logic chk_di; int cyc; } cmd_t;

  logic   clk = 1'b0;
  logic   rst = 1'b0;
  state_e dbg_state;
  int     cyc = 0;
  int     total = 0;
  int     bad = 0;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.MAX_STREAK(MAX_STREAK), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- shared bench state ----------------
  ls_item_t    ls_q[$];
  logic [31:0] if_q[$];
  logic        ls_busy = 1'b0, if_busy = 1'b0;
  rsp_t        if_exp_q[$], ls_exp_q[$];
  cmd_t        cmd_exp_q[$];
  logic [31:0] ram[16];
  logic [31:0] ref_mem[16];
  int          mem_lat = 1;
  logic        mem_drop = 1'b0;
  logic        spur_en = 1'b0;
  int          rd_due = -1;
  logic [31:0] rd_data = '0;
  int          streak = 0;
  int          next_ok = 0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, req, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: bound expired at cycle %0d", name, cyc);
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // ---------------- driver tasks / requesters ----------------
  initial begin : ls_driver
    int n;
    ls_item_t it;
    bus.ls_req = 0; bus.ls_we = 0; bus.ls_ctrl = 0; bus.ls_addr = 0; bus.ls_wdata = 0;
    forever begin
      if (ls_q.size() == 0) begin
        bus.ls_req = 1'b0;
        ls_busy    = 1'b0;
        @(posedge clk); #1;
      end else begin
        it = ls_q.pop_front();
        bus.ls_we = it.we; bus.ls_ctrl = it.ctrl; bus.ls_addr = it.addr; bus.ls_wdata = it.wdata;
        bus.ls_req = 1'b1;
        ls_busy    = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.ls_gnt && n < 400);
        if (!bus.ls_gnt) fail_now("ls_gnt_wait");
        @(posedge clk); #1;
      end
    end
  end

  initial begin : if_driver
    int n;
    bus.if_req = 0; bus.if_addr = 0;
    forever begin
      if (if_q.size() == 0) begin
        bus.if_req = 1'b0;
        if_busy    = 1'b0;
        @(posedge clk); #1;
      end else begin
        bus.if_addr = if_q.pop_front();
        bus.if_req  = 1'b1;
        if_busy     = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.if_gnt && n < 400);
        if (!bus.if_gnt) fail_now("if_gnt_wait");
        @(posedge clk); #1;
      end
    end
  end

  // ---------------- behavioural memory ----------------
  always @(negedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr[5:2]] = merge(ram[bus.mem_addr[5:2]], bus.mem_di, bus.mem_ctrl);
    if (bus.mem_rd && !mem_drop) begin
      rd_due  = cyc + mem_lat;
      rd_data = ram[bus.mem_addr[5:2]];
    end
  end

  initial begin : mem_driver
    bus.mem_dout_ready = 1'b0;
    bus.mem_dout       = '0;
    forever begin
      @(posedge clk); #1;
      if (cyc == rd_due) begin
        bus.mem_dout_ready = 1'b1;
        bus.mem_dout       = rd_data;
      end else if (spur_en && !mem_drop && cyc > rd_due && $urandom_range(0, 3) == 0) begin
        bus.mem_dout_ready = 1'b1;
        bus.mem_dout       = $urandom;
      end else begin
        bus.mem_dout_ready = 1'b0;
        bus.mem_dout       = $urandom;
      end
    end
  end

  // ---------------- reference model: predictions at grant time ----------------
  task automatic model_read(input logic is_if, input logic [31:0] addr, input logic [3:0] ctrl);
    rsp_t r;
    cmd_t c;
    r.err   = mem_drop;
    r.rdata = mem_drop ? 32'h0 : ref_mem[addr[5:2]];
    r.cyc   = cyc + 2 + (mem_drop ? TIMEOUT : mem_lat);
    c.we = 1'b0; c.ctrl = ctrl; c.addr = addr; c.di = 32'h0; c.chk_di = is_if; c.cyc = cyc + 1;
    cmd_exp_q.push_back(c);
    if (is_if) if_exp_q.push_back(r);
    else       ls_exp_q.push_back(r);
    next_ok = r.cyc;
  endtask

  task automatic model_ls();
    rsp_t r;
    cmd_t c;
    if (bus.ls_ctrl == 4'h0) begin
      r.rdata = 32'h0; r.err = 1'b1; r.cyc = cyc + 1;
      ls_exp_q.push_back(r);
      next_ok = cyc + 1;
    end else if (bus.ls_we) begin
      ref_mem[bus.ls_addr[5:2]] = merge(ref_mem[bus.ls_addr[5:2]], bus.ls_wdata, bus.ls_ctrl);
      c.we = 1'b1; c.ctrl = bus.ls_ctrl; c.addr = bus.ls_addr; c.di = bus.ls_wdata; c.chk_di = 1'b1; c.cyc = cyc + 1;
      cmd_exp_q.push_back(c);
      r.rdata = 32'h0; r.err = 1'b0; r.cyc = cyc + 2;
      ls_exp_q.push_back(r);
      next_ok = cyc + 2;
    end else begin
      model_read(1'b0, bus.ls_addr, bus.ls_ctrl);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  logic exp_gi, exp_gl, exp_c, exp_r;
  cmd_t mc;
  rsp_t mr;

  always @(negedge clk) begin
    if (rst) begin
      check("reset_rsp_outputs",
            {bus.if_gnt, bus.if_rvalid, bus.if_err, bus.if_rdata, bus.ls_gnt, bus.ls_rvalid, bus.ls_err, bus.ls_rdata}, 96'h0);
      check("reset_mem_outputs", {bus.mem_we, bus.mem_rd, bus.mem_ctrl, bus.mem_addr, bus.mem_di}, 96'h0);
      check("reset_state", dbg_state, IDLE);
      if_exp_q.delete(); ls_exp_q.delete(); cmd_exp_q.delete();
      streak  = 0;
      next_ok = cyc + 1;
    end else begin
      exp_gi = 1'b0;
      exp_gl = 1'b0;
      if (cyc >= next_ok) begin
        if (bus.if_req && (!bus.ls_req || streak == MAX_STREAK)) exp_gi = 1'b1;
        else if (bus.ls_req)                                     exp_gl = 1'b1;
      end
      if (exp_gi || exp_gl || bus.if_gnt || bus.ls_gnt)
        check("grant", {bus.if_gnt, bus.ls_gnt}, {exp_gi, exp_gl});
      if (exp_gi)      model_read(1'b1, bus.if_addr, 4'hF);
      else if (exp_gl) model_ls();
      if (!bus.if_req || exp_gi) streak = 0;
      else if (exp_gl)           streak++;

      exp_c = (cmd_exp_q.size() > 0) && (cmd_exp_q[0].cyc == cyc);
      if (exp_c) begin
        mc = cmd_exp_q.pop_front();
        check("mem_cmd",
              {bus.mem_we, bus.mem_rd, bus.mem_ctrl, bus.mem_addr, (mc.chk_di ? bus.mem_di : 32'h0)},
              {mc.we, !mc.we, mc.ctrl, mc.addr, (mc.chk_di ? mc.di : 32'h0)});
      end else if (bus.mem_we || bus.mem_rd) begin
        check("mem_cmd_unexpected", {bus.mem_we, bus.mem_rd}, 2'b00);
      end

      exp_r = (if_exp_q.size() > 0) && (if_exp_q[0].cyc == cyc);
      if (exp_r) begin
        mr = if_exp_q.pop_front();
        check("if_rsp", {bus.if_rvalid, bus.if_err, bus.if_rdata}, {1'b1, mr.err, mr.rdata});
      end else if (bus.if_rvalid) begin
        check("if_rvalid_unexpected", bus.if_rvalid, 1'b0);
      end

      exp_r = (ls_exp_q.size() > 0) && (ls_exp_q[0].cyc == cyc);
      if (exp_r) begin
        mr = ls_exp_q.pop_front();
        check("ls_rsp", {bus.ls_rvalid, bus.ls_err, bus.ls_rdata}, {1'b1, mr.err, mr.rdata});
      end else if (bus.ls_rvalid) begin
        check("ls_rvalid_unexpected", bus.ls_rvalid, 1'b0);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push_ls(input logic we, input logic [3:0] ctrl, input logic [31:0] addr, input logic [31:0] wdata);
    ls_item_t it;
    it.we = we; it.ctrl = ctrl; it.addr = addr; it.wdata = wdata;
    ls_q.push_back(it);
  endtask

  task automatic wait_quiet();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(ls_q.size() == 0 && if_q.size() == 0 && !ls_busy && !if_busy &&
                 if_exp_q.size() == 0 && ls_exp_q.size() == 0 && cmd_exp_q.size() == 0) && n < 3000);
    if (n >= 3000) fail_now("wait_quiet");
  endtask

  function automatic logic [31:0] rand_addr();
    logic [3:0] idx;
    idx = 4'($urandom_range(0, 15));
    return {26'h0, idx, 2'b00};
  endfunction

  // ---------------- main sequence ----------------
  initial begin : main
    int n;
    for (int i = 0; i < 16; i++) begin
      ram[i]     = $urandom;
      ref_mem[i] = ram[i];
    end
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // store then fetch of the same word
    @(negedge clk);
    push_ls(1'b1, 4'hF, 32'h10, 32'hCAFEBABE);
    wait_quiet();
    if_q.push_back(32'h10);
    wait_quiet();

    // simultaneous IF and LS requests
    push_ls(1'b0, 4'hF, 32'h10, 32'h0);
    if_q.push_back(32'h14);
    wait_quiet();

    // held contention: LS streak limit lets IF through
    for (int i = 0; i < 10; i++) push_ls(1'b0, 4'hF, rand_addr(), 32'h0);
    for (int i = 0; i < 3; i++)  if_q.push_back(rand_addr());
    wait_quiet();

    // memory never answers
    mem_drop = 1'b1;
    if_q.push_back(32'h20);
    wait_quiet();
    push_ls(1'b0, 4'h3, 32'h24, 32'h0);
    wait_quiet();
    mem_drop = 1'b0;

    // zero byte enables
    push_ls(1'b1, 4'h0, 32'h28, 32'h12345678);
    push_ls(1'b0, 4'h0, 32'h2C, 32'h0);
    wait_quiet();

    // randomized batches with spurious ready pulses
    spur_en = 1'b1;
    for (int b = 0; b < 12; b++) begin
      mem_lat = $urandom_range(1, 3);
      for (int i = 0; i < 6; i++) begin
        if ($urandom_range(0, 1) == 1)
          push_ls(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), rand_addr(), $urandom);
        else
          if_q.push_back(rand_addr());
      end
      wait_quiet();
    end
    spur_en = 1'b0;

    // reset while waiting for read data; the late ready must be ignored
    mem_lat = 3;
    if_q.push_back(32'h30);
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.if_gnt && n < 50);
    if (!bus.if_gnt) fail_now("reset_test_gnt");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("post_reset_no_rvalid", {bus.if_rvalid, bus.ls_rvalid}, 2'b00);
    end
    check("post_reset_state", dbg_state, IDLE);
    mem_lat = 1;
    if_q.push_back(32'h10);
    push_ls(1'b0, 4'hF, 32'h14, 32'h0);
    wait_quiet();

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
